// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2,
    TURN = 2'd3
  } state_e;

  // bus_sel encoding (also used to record the last owner).
  localparam logic MASTER1 = 1'b0;
  localparam logic MASTER2 = 1'b1;

  // Default grant hold limit, in cycles.
  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/bus_watchdog.sv
// Saturating grant-hold counter. It is cleared while no grant is active
// and counts every granted cycle. expire_o flags the last permitted grant
// cycle, which is the cycle where the count equals TIMEOUT-1.
module bus_watchdog
  import bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise increment and stick at the maximum.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && (count_q == EXPIRE_AT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a one-cycle turnaround between
// owners and a watchdog that revokes over-long grants. A revoked master
// stays masked until it drops its request for at least one cycle.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic m1_req,
  input  logic m2_req,
  input  logic m1_done,
  input  logic m2_done,
  output logic m1_grant,
  output logic m2_grant,
  output logic bus_sel,
  output logic bus_busy,
  output logic timeout
);

  state_e state_q, state_d;
  logic   last_owner_q, last_owner_d;
  logic   mask1_q, mask1_d;
  logic   mask2_q, mask2_d;
  logic   m1_grant_q, m1_grant_d;
  logic   m2_grant_q, m2_grant_d;
  logic   bus_sel_q, bus_sel_d;
  logic   bus_busy_q, bus_busy_d;
  logic   timeout_q, timeout_d;

  logic   eff1_s, eff2_s;
  logic   owning_s;
  logic   wd_expire_s;

  assign owning_s = (state_q == OWN1) || (state_q == OWN2);
  assign eff1_s   = m1_req & ~mask1_q;
  assign eff2_s   = m2_req & ~mask2_q;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (~owning_s),
    .enable_i (owning_s),
    .expire_o (wd_expire_s)
  );

  // Next state, round-robin pointer, masks and next output values.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    mask1_d      = mask1_q;
    mask2_d      = mask2_q;
    timeout_d    = 1'b0;

    case (state_q)
      IDLE, TURN: begin
        if (eff1_s && eff2_s) begin
          state_d = (last_owner_q == MASTER1) ? OWN2 : OWN1;
        end else if (eff1_s) begin
          state_d = OWN1;
        end else if (eff2_s) begin
          state_d = OWN2;
        end else begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        // A release in the expiry cycle takes priority over the revoke.
        if (m1_done || !m1_req) begin
          state_d = TURN;
        end else if (wd_expire_s) begin
          state_d   = TURN;
          timeout_d = 1'b1;
          mask1_d   = 1'b1;
        end else begin
          state_d = OWN1;
        end
      end
      OWN2: begin
        if (m2_done || !m2_req) begin
          state_d = TURN;
        end else if (wd_expire_s) begin
          state_d   = TURN;
          timeout_d = 1'b1;
          mask2_d   = 1'b1;
        end else begin
          state_d = OWN2;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A dropped request always clears that master's mask.
    if (!m1_req) begin
      mask1_d = 1'b0;
    end else begin
      mask1_d = mask1_d;
    end
    if (!m2_req) begin
      mask2_d = 1'b0;
    end else begin
      mask2_d = mask2_d;
    end

    m1_grant_d = (state_d == OWN1);
    m2_grant_d = (state_d == OWN2);
    bus_busy_d = (state_d != IDLE);

    if (state_d == OWN1) begin
      bus_sel_d    = MASTER1;
      last_owner_d = MASTER1;
    end else if (state_d == OWN2) begin
      bus_sel_d    = MASTER2;
      last_owner_d = MASTER2;
    end else begin
      bus_sel_d    = bus_sel_q;
    end
  end

  // State and registered outputs; reset makes master 1 win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= MASTER2;
      mask1_q      <= 1'b0;
      mask2_q      <= 1'b0;
      m1_grant_q   <= 1'b0;
      m2_grant_q   <= 1'b0;
      bus_sel_q    <= MASTER1;
      bus_busy_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      mask1_q      <= mask1_d;
      mask2_q      <= mask2_d;
      m1_grant_q   <= m1_grant_d;
      m2_grant_q   <= m2_grant_d;
      bus_sel_q    <= bus_sel_d;
      bus_busy_q   <= bus_busy_d;
      timeout_q    <= timeout_d;
    end
  end

  assign m1_grant = m1_grant_q;
  assign m2_grant = m2_grant_q;
  assign bus_sel  = bus_sel_q;
  assign bus_busy = bus_busy_q;
  assign timeout  = timeout_q;

endmodule
